inst_enc_loader: RTL and testbench
==================================

Name: inst_enc_loader

Overview:
- Instruction encoder and loader: the inverse of the immediate decoder.
- Accepts decoded instruction fields (opcode, registers, funct, full 32-bit immediate) over a valid/ready stream.
- Packs each into a 32-bit RV32 instruction word using the same opcode-to-format map the decode side uses.
- Writes the words sequentially into instruction memory starting from a base address. Used by the bench and boot loader to build programs without an external assembler.

Parameters:
- AW, 32, instruction-memory byte-address width.
- CW, 16, width of the instruction and error counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load session; sampled in IDLE only.
- base_addr  in  AW  byte address of the first word; low 2 bits are ignored (forced 0).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the session's last word has been written.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_last  in  1  marks the final bundle of the session.
- in_opcode  in  7  opcode.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7.
- in_imm  in  32  sign-extended immediate value (not pre-shifted).
- wr_en  out  1  memory write request.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  AW  write byte address.
- wr_data  out  32  encoded instruction word.
- err  out  1  one-cycle pulse, coincident with acceptance of a bundle that had an error.
- err_count  out  CW  errored bundles this session, saturating.
- inst_count  out  CW  words written this session, saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address 0.
- FSM states:
  - IDLE, start=1: load addr = {base_addr[AW-1:2],2'b00}, clear both counters, go to RUN.
  - RUN, accepted bundle with in_last=1: go to DRAIN.
  - DRAIN, last word's write handshake completes: pulse done, go to IDLE.
  - start outside IDLE: ignored.
- in_ready = (state==RUN) && (!wr_en || wr_ready). Combinational; depends on wr_ready, not on in_valid.
- Latency: one cycle. An accepted bundle appears on wr_en/wr_addr/wr_data the next cycle.
- Output hold: while wr_en && !wr_ready, wr_en, wr_addr and wr_data hold stable.
- Write completion: each completed write advances addr by 4, modulo 2^AW (wraps silently), and increments inst_count.
- Back-to-back: a new bundle may be accepted in the same cycle as the previous write completes. Throughput is one word per clock.
- Encoding by opcode:
  - I layout (ItypeL/ItypeA/ItypeJ): imm[11:0] → [31:20]; rs1, funct3, rd. funct7 ignored, except for shifts, where funct7 → [31:25] and imm[4:0] → [24:20].
  - Stype: imm[11:5] → [31:25], imm[4:0] → [11:7].
  - Btype: imm[12] → [31], imm[10:5] → [30:25], imm[4:1] → [11:8], imm[11] → [7].
  - UtypeL/UtypeU: imm[31:12] → [31:12].
  - Jtype: imm[20] → [31], imm[10:1] → [30:21], imm[11] → [20], imm[19:12] → [19:12].
  - Mtype: M_LD uses the I layout, M_ST uses the S layout, any other funct3 uses the R layout with funct7.
  - R layout (OP and Mtype-other): funct7, rs2, rs1, funct3, rd.
- Range check (error when violated):
  - I/S/M: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
  - Unknown opcode: always an error.
- On error: word is NOP 32'h00000013, written normally at the next address; err pulses; err_count increments.
- Reset mid-session: immediate return to IDLE. Any pending write is dropped and no done pulse is produced.

Decomposition:
- Opcode and M_LD/M_ST codes: existing define.vh.
- Add to define.vh: `NOP_INST, FSM state encodings, and format enum (FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_BAD).
- Sub-module inst_pack: purely combinational fields → {word, err}. The top level holds the FSM, output register, address and counters.

Test Plan:
- addi x1,x2,-1 (op 0010011, rd1, rs1 2, f3 0, imm -1), base 0x100 → wr_addr 0x100, wr_data 0xFFF10093 one cycle after accept; err=0.
- Stream of three bundles, wr_ready=1, last on the third:
  - sw x5,8(x2) → 0x00512423 @0x100.
  - beq x1,x2,-4 → 0xFE208EE3 @0x104.
  - jal x1,2048 → 0x001000EF @0x108.
  - done pulses on the third write; inst_count=3.
- lui x1,0x12345000 with wr_ready low for 3 cycles → wr_data 0x123450B7 held stable, in_ready=0, single write on release.
- addi imm=2048 → wr_data 0x00000013, err pulse, err_count=1. beq imm=3 → NOP, err_count=2.
- base_addr = 2^AW-4, two bundles → second write at address 0 (wrap).
- Assert rstn low while wr_en=1 and stalled → all outputs 0 asynchronously, no done; a new start after reset works normally.

Source files
------------

// File: rtl/inst_enc_loader_pkg.sv
// Shared opcodes, formats and FSM states for the instruction encoder/loader.
// Everything that must agree between the pack logic and the loader lives here.
package inst_enc_loader_pkg;

    localparam logic [6:0] OpItypeL = 7'b0000011;
    localparam logic [6:0] OpItypeA = 7'b0010011;
    localparam logic [6:0] OpItypeJ = 7'b1100111;
    localparam logic [6:0] OpStype  = 7'b0100011;
    localparam logic [6:0] OpBtype  = 7'b1100011;
    localparam logic [6:0] OpUtypeL = 7'b0110111;
    localparam logic [6:0] OpUtypeU = 7'b0010111;
    localparam logic [6:0] OpJtype  = 7'b1101111;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpMtype  = 7'b0001011;

    localparam logic [2:0] MLd = 3'b010;
    localparam logic [2:0] MSt = 3'b011;

    localparam logic [31:0] NopInst = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    typedef enum logic [2:0] {
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtR,
        FmtBad
    } fmt_e;

    // True when v[31:lo] are all copies of one bit, i.e. v fits as a signed lo+1 bit value.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lo);
        logic [31:0] s;
        s = 32'($signed(v) >>> lo);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_enc_loader_if.sv
// Field-bundle input stream, session control and memory-write bus of the loader.
// slave is the loader's view, master is the driver/memory side.
interface inst_enc_loader_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 16
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;

    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;

    logic          wr_en;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    logic          err;
    logic [CW-1:0] err_count;
    logic [CW-1:0] inst_count;

    modport slave (
        input  start, base_addr, in_valid, in_last, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, wr_ready,
        output busy, done, in_ready, wr_en, wr_addr, wr_data, err, err_count, inst_count
    );

    modport master (
        output start, base_addr, in_valid, in_last, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, wr_ready,
        input  busy, done, in_ready, wr_en, wr_addr, wr_data, err, err_count, inst_count
    );

endinterface

// File: rtl/inst_enc_loader_pack.sv
// Combinational packer: decoded fields -> RV32 instruction word plus range error.
// Errored bundles produce a NOP so the program image keeps its layout.
module inst_pack
    import inst_enc_loader_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        err_o
);

    fmt_e        fmt;
    logic        is_shift;
    logic [31:0] raw;
    logic        bad;

    always_comb begin
        fmt = FmtBad;
        case (opcode_i)
            OpItypeL, OpItypeA, OpItypeJ: fmt = FmtI;
            OpStype:                      fmt = FmtS;
            OpBtype:                      fmt = FmtB;
            OpUtypeL, OpUtypeU:           fmt = FmtU;
            OpJtype:                      fmt = FmtJ;
            OpRtype:                      fmt = FmtR;
            OpMtype: begin
                if (funct3_i == MLd) begin
                    fmt = FmtI;
                end else if (funct3_i == MSt) begin
                    fmt = FmtS;
                end else begin
                    fmt = FmtR;
                end
            end
            default:                      fmt = FmtBad;
        endcase
    end

    // slli/srli/srai carry funct7 in the upper immediate bits.
    assign is_shift = (opcode_i == OpItypeA) && (funct3_i[1:0] == 2'b01);

    always_comb begin
        raw = NopInst;
        bad = 1'b0;
        case (fmt)
            FmtI: begin
                raw = is_shift ? {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i}
                               : {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                bad = !upper_uniform(imm_i, 11);
            end
            FmtS: begin
                raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                bad = !upper_uniform(imm_i, 11);
            end
            FmtB: begin
                raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                       opcode_i};
                bad = !upper_uniform(imm_i, 12) || imm_i[0];
            end
            FmtU: begin
                raw = {imm_i[31:12], rd_i, opcode_i};
                bad = |imm_i[11:0];
            end
            FmtJ: begin
                raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                bad = !upper_uniform(imm_i, 20) || imm_i[0];
            end
            FmtR: begin
                raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                bad = 1'b0;
            end
            default: begin
                raw = NopInst;
                bad = 1'b1;
            end
        endcase
    end

    assign word_o = bad ? NopInst : raw;
    assign err_o  = bad;

endmodule

// File: rtl/inst_enc_loader.sv
// Session FSM, one-deep output register, address and counters of the instruction loader.
// Encoded words are written sequentially from a word-aligned base address.
module inst_enc_loader
    import inst_enc_loader_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 16
) (
    input logic                clk,
    input logic                rstn,
    inst_enc_loader_if.slave   bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [CW-1:0] inst_cnt_q, inst_cnt_d;

    logic [31:0]   pack_word;
    logic          pack_err;
    logic          in_ready;
    logic          accept;
    logic          write_done;

    inst_pack u_pack (
        .opcode_i (bus.in_opcode),
        .rd_i     (bus.in_rd),
        .rs1_i    (bus.in_rs1),
        .rs2_i    (bus.in_rs2),
        .funct3_i (bus.in_funct3),
        .funct7_i (bus.in_funct7),
        .imm_i    (bus.in_imm),
        .word_o   (pack_word),
        .err_o    (pack_err)
    );

    assign write_done = wr_en_q && bus.wr_ready;
    assign in_ready   = (state_q == StRun) && (!wr_en_q || bus.wr_ready);
    assign accept     = bus.in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_en_d    = wr_en_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        inst_cnt_d = inst_cnt_q;

        // addr_q always names the slot of the word currently (or next) in the output register.
        if (write_done) begin
            wr_en_d    = 1'b0;
            addr_d     = addr_q + AW'(4);
            inst_cnt_d = (inst_cnt_q == '1) ? inst_cnt_q : inst_cnt_q + CW'(1);
        end

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_data_d = pack_word;
            if (pack_err) begin
                err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d     = {bus.base_addr[AW-1:2], 2'b00};
                    err_cnt_d  = '0;
                    inst_cnt_d = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (accept && bus.in_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (write_done) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
            inst_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_cnt_q  <= err_cnt_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.err        = accept && pack_err;
    assign bus.err_count  = err_cnt_q;
    assign bus.inst_count = inst_cnt_q;

endmodule

// File: tb/tb_inst_enc_loader.sv
// Directed bench for inst_enc_loader: expected writes are queued when a bundle is sent
// and checked against the memory-write port as each write completes.
module tb_inst_enc_loader;
    import inst_enc_loader_pkg::*;

    logic clk;
    logic rstn;

    inst_enc_loader_if #(.AW(32), .CW(16)) bus ();

    inst_enc_loader #(.AW(32), .CW(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t     sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    logic [31:0] exp_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: a write completes at the next posedge when wr_en && wr_ready here.
    always @(negedge clk) begin
        if (rstn && bus.wr_en && bus.wr_ready) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'(1));
            end else begin
                wr_exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                chk("wr_data", 64'(bus.wr_data), 64'(e.data));
            end
        end
    end

    task automatic push_exp(input logic [31:0] word);
        wr_exp_t e;
        e.addr = exp_addr;
        e.data = word;
        sb.push_back(e);
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic start_s(input logic [31:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        exp_addr      = {base[31:2], 2'b00};
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic last);
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
    endtask

    task automatic send(input string tag, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_word, input logic exp_err);
        int n;
        set_fields(op, rd, rs1, rs2, f3, f7, imm, last);
        push_exp(exp_word);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_accept"}, 64'(bus.in_ready), 64'(1));
        chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.done && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 64'(bus.done), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_base;
        logic saw_done;

        rstn          = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.wr_ready  = 1'b0;
        set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        bus.in_valid  = 1'b0;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({bus.busy, bus.done, bus.in_ready, bus.wr_en, bus.err}), 64'(0));
        chk("rst_addr", 64'(bus.wr_addr), 64'(0));
        chk("rst_data", 64'(bus.wr_data), 64'(0));
        chk("rst_counts", 64'({bus.err_count, bus.inst_count}), 64'(0));
        @(posedge clk);
        #1 rstn = 1'b1;
        bus.wr_ready = 1'b1;

        // addi x1,x2,-1 at 0x100, one-cycle latency
        start_s(32'h0000_0100);
        @(negedge clk);
        chk("busy_run", 64'(bus.busy), 64'(1));
        @(posedge clk);
        #1;
        send("addi", OpItypeA, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1,
             32'hFFF1_0093, 1'b0);
        @(negedge clk);
        chk("lat_wr_en", 64'(bus.wr_en), 64'(1));
        chk("lat_wr_addr", 64'(bus.wr_addr), 64'h100);
        @(posedge clk);
        #1;
        wait_done("addi_done");
        chk("addi_inst_count", 64'(bus.inst_count), 64'(1));

        // sw / beq / jal back to back
        start_s(32'h0000_0100);
        send("sw", OpStype, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0051_2423, 1'b0);
        send("beq", OpBtype, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0,
             32'hFE20_8EE3, 1'b0);
        send("jal", OpJtype, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h0010_00EF, 1'b0);
        wait_done("stream_done");
        chk("stream_inst_count", 64'(bus.inst_count), 64'(3));
        @(negedge clk);
        chk("done_one_pulse", 64'(bus.done), 64'(0));
        chk("idle_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1;

        // lui stalled by wr_ready, next bundle must wait
        start_s(32'h0000_0400);
        bus.wr_ready = 1'b0;
        set_fields(OpUtypeL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
        push_exp(32'h1234_50B7);
        @(negedge clk);
        chk("stall_lui_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        set_fields(OpRtype, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        push_exp(32'h0020_81B3);
        wr_base = wr_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("stall_wr_en", 64'(bus.wr_en), 64'(1));
            chk("stall_wr_data", 64'(bus.wr_data), 64'h1234_50B7);
            chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        chk("stall_no_write", 64'(wr_cnt - wr_base), 64'(0));
        bus.wr_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        wait_done("stall_done");
        chk("stall_writes", 64'(wr_cnt - wr_base), 64'(2));
        chk("stall_inst_count", 64'(bus.inst_count), 64'(2));

        // range errors and other formats
        start_s(32'h0000_0200);
        send("addi_big", OpItypeA, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0,
             NopInst, 1'b1);
        send("beq_odd", OpBtype, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, NopInst, 1'b1);
        chk("err_count_2", 64'(bus.err_count), 64'(2));
        send("srai", OpItypeA, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd5, 1'b0, 32'h4052_5193, 1'b0);
        send("add", OpRtype, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0020_81B3, 1'b0);
        send("mst", OpMtype, 5'd0, 5'd1, 5'd3, MSt, 7'd0, 32'd4, 1'b0, 32'h0030_B20B, 1'b0);
        send("auipc_low", OpUtypeU, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, NopInst, 1'b1);
        send("bad_op", 7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, NopInst, 1'b1);
        wait_done("err_done");
        chk("err_count_4", 64'(bus.err_count), 64'(4));
        chk("err_inst_count", 64'(bus.inst_count), 64'(7));

        // address wrap; low base bits ignored
        start_s(32'hFFFF_FFFF);
        send("wrap0", OpItypeA, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0010_0093, 1'b0);
        send("wrap1", OpRtype, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0020_81B3, 1'b0);
        wait_done("wrap_done");
        chk("wrap_err_count_cleared", 64'(bus.err_count), 64'(0));

        // asynchronous reset while a write is stalled
        start_s(32'h0000_0300);
        bus.wr_ready = 1'b0;
        send("rst_addi", OpItypeA, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0,
             32'hFFF1_0093, 1'b0);
        @(negedge clk);
        chk("pre_rst_wr_en", 64'(bus.wr_en), 64'(1));
        #1 rstn = 1'b0;
        #1;
        chk("async_ctrl", 64'({bus.busy, bus.done, bus.in_ready, bus.wr_en, bus.err}), 64'(0));
        chk("async_addr_data", 64'({bus.wr_addr, bus.wr_data}), 64'(0));
        chk("async_counts", 64'({bus.err_count, bus.inst_count}), 64'(0));
        sb.delete();
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_done = saw_done | bus.done;
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        bus.wr_ready = 1'b1;
        @(negedge clk);
        saw_done = saw_done | bus.done;
        chk("rst_no_done", 64'(saw_done), 64'(0));
        @(posedge clk);
        #1;
        start_s(32'h0000_0040);
        send("post_rst_jal", OpJtype, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1,
             32'h0010_00EF, 1'b0);
        wait_done("post_rst_done");
        chk("post_rst_inst_count", 64'(bus.inst_count), 64'(1));
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
